// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with registered read data, level flags and sticky error flags.
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rd,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        data_out,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rd_valid_q, rd_valid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_acc, rd_acc;
  assign empty        = cnt_q == '0;
  assign full         = cnt_q == CNT_W'(DEPTH);
  assign almost_full  = cnt_q >= CNT_W'(AF_LVL);
  assign almost_empty = cnt_q <= CNT_W'(AE_LVL);
  assign fifo_cnt     = cnt_q;
  assign data_out     = dout_q;
  assign rd_valid     = rd_valid_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  // A read frees a slot in the same edge, so a full FIFO still takes a write alongside it.
  always_comb begin
    rd_acc     = rd && !empty;
    wr_acc     = wr && (!full || rd_acc);
    wr_ptr_d   = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d      = (wr_acc && !rd_acc) ? cnt_q + CNT_W'(1) :
                 (rd_acc && !wr_acc) ? cnt_q - CNT_W'(1) : cnt_q;
    dout_d     = rd_acc ? mem[rd_ptr_q] : dout_q;
    rd_valid_d = rd_acc;
    ovf_d      = (wr && !wr_acc) || (ovf_q && !clr_err);
    udf_d      = (rd && empty) || (udf_q && !clr_err);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end
  // Storage has no reset; an entry is only read after it has been rewritten.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= data_in;
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: vector table, directed corner sequences and random traffic against a queue model.
module tb_sync_fifo_param;
  localparam int D = 8;
  logic       clk = 1'b0, rst_n = 1'b0, wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
  logic [7:0] data_in = 8'h00, data_out;
  logic       rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0] fifo_cnt;
  int         n_cmp = 0, n_bad = 0;
  logic [7:0] mq[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_vld = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       clr;
    logic [7:0] dout;
    logic       vld;
    int         cnt;
    logic       ovf;
    logic       udf;
  } vec_t;
  vec_t tbl[10];
  always #5 clk = ~clk;
  sync_fifo_param #(.DATA_W(8), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .rd(rd), .clr_err(clr_err),
    .data_out(data_out), .rd_valid(rd_valid), .fifo_cnt(fifo_cnt), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_model();
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("rd_valid", 32'(rd_valid), 32'(m_vld));
    chk("fifo_cnt", 32'(fifo_cnt), mq.size());
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == D));
    chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 2));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= D - 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
  endtask
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic ra, wa;
    wr = w; data_in = d; rd = r; clr_err = c;
    ra = r && mq.size() != 0;
    wa = w && (mq.size() < D || ra);
    m_udf = (r && mq.size() == 0) || (m_udf && !c);
    m_ovf = (w && !wa) || (m_ovf && !c);
    m_vld = ra;
    if (ra) m_dout = mq.pop_front();
    if (wa) mq.push_back(d);
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    check_model();
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    mq.delete(); m_dout = 8'h00; m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    check_model();
    #1 rst_n = 1'b1;
  endtask
  initial begin
    logic [7:0] wq[$], got[$];
    int max_cnt, pw;
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 2, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 1'b1, 1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h33, 1'b1, 1'b0, 8'h22, 1'b1, 1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b0, 1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 1'b1, 0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 1'b0, 0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h33, 1'b0, 1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b0, 1, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 1'b1, 0, 1'b0, 1'b0};
    async_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].wr, tbl[i].din, tbl[i].rd, tbl[i].clr);
      chk($sformatf("t%0d_dout", i), 32'(data_out), 32'(tbl[i].dout));
      chk($sformatf("t%0d_vld", i), 32'(rd_valid), 32'(tbl[i].vld));
      chk($sformatf("t%0d_cnt", i), 32'(fifo_cnt), tbl[i].cnt);
      chk($sformatf("t%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      chk($sformatf("t%0d_udf", i), 32'(underflow), 32'(tbl[i].udf));
      chk($sformatf("t%0d_empty", i), 32'(empty), 32'(tbl[i].cnt == 0));
      chk($sformatf("t%0d_ae", i), 32'(almost_empty), 32'(tbl[i].cnt <= 2));
    end
    // fill to full, then overflow
    async_reset();
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(full), 1);
    chk("fill_cnt", 32'(fifo_cnt), 8);
    cyc(1'b1, 8'h09, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_cnt", 32'(fifo_cnt), 8);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk($sformatf("drain%0d_dout", i), 32'(data_out), i);
      chk($sformatf("drain%0d_vld", i), 32'(rd_valid), 1);
    end
    chk("drain_empty", 32'(empty), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_set", 32'(underflow), 1);
    chk("udf_dout_hold", 32'(data_out), 8);
    chk("udf_vld", 32'(rd_valid), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    // simultaneous rd/wr while full
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("fullrw_dout", 32'(data_out), 1);
    chk("fullrw_cnt", 32'(fifo_cnt), 8);
    chk("fullrw_ovf", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fullrw_last", 32'(data_out), 32'hAA);
    // simultaneous rd/wr while empty
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("emptyrw_cnt", 32'(fifo_cnt), 1);
    chk("emptyrw_vld", 32'(rd_valid), 0);
    chk("emptyrw_udf", 32'(underflow), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("emptyrw_next", 32'(data_out), 32'h55);
    // streaming with pointer wrap
    async_reset();
    max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'(8'h40 + i), i >= 6, 1'b0);
      wq.push_back(8'(8'h40 + i));
      if (rd_valid) got.push_back(data_out);
      if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
      if (i == 1) chk("ae_at2", 32'(almost_empty), 1);
      if (i == 2) chk("ae_at3", 32'(almost_empty), 0);
      if (i == 4) chk("af_at5", 32'(almost_full), 0);
      if (i == 5) chk("af_at6", 32'(almost_full), 1);
    end
    for (int k = 0; k < D + 2; k++)
      if (fifo_cnt != 0) begin
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        if (rd_valid) got.push_back(data_out);
      end
    chk("stream_count", got.size(), 20);
    for (int i = 0; i < 20 && i < got.size(); i++)
      chk($sformatf("stream_order%0d", i), 32'(got[i]), 32'(wq[i]));
    chk("stream_max_cnt", 32'(max_cnt <= D), 1);
    // reset mid-operation
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_cnt", 32'(fifo_cnt), 5);
    chk("pre_rst_ovf", 32'(overflow), 1);
    async_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_noerr_ovf", 32'(overflow), 0);
    chk("clr_noerr_udf", 32'(underflow), 0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_first", 32'(data_out), 32'h77);
    // random traffic with alternating fill/drain bias
    for (int n = 0; n < 400; n++) begin
      pw = ((n / 40) % 2 == 0) ? 75 : 25;
      cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < 100 - pw,
          $urandom_range(0, 15) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
